uart_rx_sampler: RTL
====================

# uart_rx_sampler

Serial receiver for the UART core. Consumes the one-clk-wide 16x oversampling pulse from the baud clock generator, recovers start/data/parity/stop bits from the asynchronous rx line, and presents each received character with a ready/acknowledge handshake and per-character error flags to the FIFO/register side. Runs entirely on the system clock; baud_clock is a clock enable, never a clock.

## Interface
- No parameters; build-time option in Configuration.
- clk  in  1  system clock
- aresetn  in  1  asynchronous, active-low reset
- baud_clock  in  1  16x baud enable pulse, one clk wide
- rx  in  1  asynchronous serial input, idle high
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  parity bit present after data
- odd_n_even  in  1  1 = odd parity, 0 = even
- read_rx_byte  in  1  one-clk acknowledge; consumes rx_byte
- rx_byte  out  8  received character, LSB first on line; bit 7 = 0 in 7-bit mode
- rx_ready  out  1  rx_byte valid, held until acknowledged
- parity_err  out  1  parity mismatch for character in rx_byte
- framing_err  out  1  stop bit sampled 0 for character in rx_byte
- overflow  out  1  sticky; character lost because rx_ready was still set

## Operation
- rx passes through 2-flop synchronizer (reset 1) -> rx_s. All FSM activity occurs only on clk edges where baud_clock = 1.
- samp_cnt (4 bits) counts ticks within current bit, 0..15, wraps; tick 0 = bit start.
- Bit value decided at samp_cnt = 9 (see Configuration); state advances to next bit when samp_cnt = 15.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: tick with rx_s = 0 -> START, samp_cnt <= 1 (detection tick counts as tick 0).
- START: decision 1 -> IDLE (glitch rejected); decision 0 -> continue; at 15 -> DATA, bit_cnt <= 0.
- DATA: decision shifts bit into shreg[7] (shift right); at 15 bit_cnt++; after bit_cnt = 7 (bit8 = 1) or 6 (bit8 = 0) -> PARITY if parity_en else STOP.
- PARITY: decision stored as par_bit; at 15 -> STOP.
- STOP: at decision, character delivered (below); decision 1 -> IDLE immediately (no wait for tick 15); decision 0 -> BREAK.
- BREAK: tick with rx_s = 1 -> IDLE.
- Delivery: data = bit8 ? shreg : {1'b0, shreg[7:1]}; expected parity = XOR(data bits) ^ odd_n_even; parity_err <= parity_en & (par_bit != expected); framing_err <= ~stop decision.
- Handshake: read_rx_byte clears rx_ready and overflow. Delivery with rx_ready = 0 loads rx_byte/flags, sets rx_ready. Delivery with rx_ready = 1 and no read that cycle: character discarded, rx_byte/flags unchanged, overflow <= 1. Delivery and read in same cycle: read wins, new character loaded, rx_ready stays 1, overflow 0.
- read_rx_byte with rx_ready = 0: no effect.
- bit8/parity_en/odd_n_even are static during a frame; changes mid-frame give undefined character, no hang.

## Timing
- Reset values: rx_byte 0x00, rx_ready 0, parity_err 0, framing_err 0, overflow 0, FSM IDLE, synchronizer 1.
- Latency: rx falling edge to IDLE detection <= 2 clk + 1 tick. Outputs update 1 clk after the STOP decision tick: (N-1)*16 + 9 ticks after detection, N = total frame bits incl. start/stop.
- Reset mid-frame: all state returns to reset values; partial character lost; no flag set.
- baud_clock stuck low: FSM and counters frozen, handshake logic still responds to read_rx_byte.

## Configuration
- RX_MAJORITY_VOTE_EN defined: rx_s captured at samp_cnt 7, 8, 9; decision = majority of three (2-of-3).
- Undefined: decision = rx_s captured at samp_cnt 8, registered, used at samp_cnt 9. Decision timing identical in both builds.

## Test plan
- baud_clock every 4 clk, 8N1, send 0x55 -> rx_byte = 0x55, rx_ready = 1, all flags 0; read_rx_byte -> rx_ready = 0 next clk.
- 8E1 send 0xA3 with parity bit 1 (correct is 0) -> rx_byte = 0xA3, parity_err = 1; resend with 0 -> parity_err = 0. 7O1 send 0x41 -> rx_byte = 0x41.
- rx low for 3 ticks then high -> START aborts to IDLE, rx_ready stays 0; following 0x3C received correctly.
- Send 0x12 then 0x34 without read -> rx_byte = 0x12, overflow = 1; read -> rx_ready = 0, overflow = 0. Read coincident with 0x34 delivery -> rx_byte = 0x34, overflow = 0.
- Send 0x7E with stop bit 0, hold rx low 40 ticks -> framing_err = 1, rx_ready = 1; release, send 0x01 -> rx_byte = 0x01, framing_err = 0.
- One-tick glitch on data bit 3 at samp_cnt 8: with RX_MAJORITY_VOTE_EN 0xF0 received intact; without, received 0xF8.

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Receiver-side bundle: line/config inputs and the character handshake toward the FIFO side.
// The slave modport is the receiver; the master modport is whoever drives the line and reads characters.
interface uart_rx_sampler_if;
    logic       baud_clock;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    modport master (
        output baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte,
        input  rx_byte, rx_ready, parity_err, framing_err, overflow
    );

    modport slave (
        input  baud_clock, rx, bit8, parity_en, odd_n_even, read_rx_byte,
        output rx_byte, rx_ready, parity_err, framing_err, overflow
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery with a ready/ack character register.
// Outputs update 1 clk after the stop-bit decision tick; a new character arriving while rx_ready is held is dropped and sets overflow.
// Build option RX_MAJORITY_VOTE_EN: bit decision is the 2-of-3 vote of ticks 7/8/9 instead of the tick-8 sample.
module uart_rx_sampler (
    input  logic             clk,
    input  logic             aresetn,
    uart_rx_sampler_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic [3:0] r_samp_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_par_bit;
    logic       r_smp8;

    logic [7:0] r_rx_byte;
    logic       r_rx_ready;
    logic       r_parity_err;
    logic       r_framing_err;
    logic       r_overflow;

    logic       w_dec_tick;
    logic       w_end_tick;
    logic       w_decision;
    logic       w_last_bit;
    logic       w_deliver;
    logic       w_read;
    logic [7:0] w_data;
    logic       w_par_exp;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_dec_tick = bus.baud_clock && (r_samp_cnt == 4'd9);
    assign w_end_tick = bus.baud_clock && (r_samp_cnt == 4'd15);

`ifdef RX_MAJORITY_VOTE_EN
    logic r_smp7;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_smp7 <= 1'b1;
        end else if (bus.baud_clock && (r_samp_cnt == 4'd7)) begin
            r_smp7 <= r_rx_s;
        end
    end

    // Third vote is the live tick-9 sample so the decision lands on the same tick as the plain build.
    assign w_decision = (r_smp7 & r_smp8) | (r_smp7 & r_rx_s) | (r_smp8 & r_rx_s);
`else
    assign w_decision = r_smp8;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_smp8 <= 1'b1;
        end else if (bus.baud_clock && (r_samp_cnt == 4'd8)) begin
            r_smp8 <= r_rx_s;
        end
    end

    assign w_last_bit = (r_bit_cnt == (bus.bit8 ? 3'd7 : 3'd6));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_deliver    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.baud_clock && !r_rx_s) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_dec_tick && w_decision) begin
                    w_next_state = ST_IDLE;
                end else if (w_end_tick) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_end_tick && w_last_bit) begin
                    w_next_state = bus.parity_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_end_tick) begin
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_dec_tick) begin
                    w_deliver    = 1'b1;
                    w_next_state = w_decision ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (bus.baud_clock && r_rx_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The detection tick is tick 0 of the start bit, so START begins counting at 1.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_samp_cnt <= 4'd0;
        end else if (bus.baud_clock) begin
            if ((w_next_state == ST_IDLE) || (w_next_state == ST_BREAK)) begin
                r_samp_cnt <= 4'd0;
            end else if (r_state == ST_IDLE) begin
                r_samp_cnt <= 4'd1;
            end else begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_bit_cnt <= 3'd0;
        end else if (w_end_tick) begin
            if (r_state == ST_START) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == ST_DATA) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_shreg   <= 8'h00;
            r_par_bit <= 1'b0;
        end else if (w_dec_tick) begin
            if (r_state == ST_DATA) begin
                r_shreg <= {w_decision, r_shreg[7:1]};
            end
            if (r_state == ST_PARITY) begin
                r_par_bit <= w_decision;
            end
        end
    end

    // In 7-bit mode only seven shifts happen, leaving the character in shreg[7:1].
    assign w_data    = bus.bit8 ? r_shreg : {1'b0, r_shreg[7:1]};
    assign w_par_exp = (^w_data) ^ bus.odd_n_even;
    assign w_read    = bus.read_rx_byte && r_rx_ready;

    // A read in the delivery cycle frees the register, so the new character is taken rather than dropped.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx_byte     <= 8'h00;
            r_rx_ready    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (w_deliver) begin
            if (!r_rx_ready || w_read) begin
                r_rx_byte     <= w_data;
                r_rx_ready    <= 1'b1;
                r_parity_err  <= bus.parity_en && (r_par_bit != w_par_exp);
                r_framing_err <= ~w_decision;
                r_overflow    <= 1'b0;
            end else begin
                r_overflow    <= 1'b1;
            end
        end else if (w_read) begin
            r_rx_ready <= 1'b0;
            r_overflow <= 1'b0;
        end
    end

    assign bus.rx_byte     = r_rx_byte;
    assign bus.rx_ready    = r_rx_ready;
    assign bus.parity_err  = r_parity_err;
    assign bus.framing_err = r_framing_err;
    assign bus.overflow    = r_overflow;

endmodule
